// File: rtl/ram_burst_pkg.sv
// rtl/ram_burst_pkg.sv - state encoding and size defaults for the RAM burst controller
package ram_burst_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int DATA_W_DEFAULT = 16;
    localparam int BUF_DEPTH      = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/ram_burst_outbuf.sv
// rtl/ram_burst_outbuf.sv - 2-entry read-data FIFO with valid/ready output
module ram_burst_outbuf
    import ram_burst_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // storage needs no reset: entries are only read once count covers them
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; push and pop in the same cycle leave count unchanged
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst command to single-port RAM access controller; RAM_BURST_WRAP_EN selects address wrap instead of bounds rejection
module ram_burst_ctrl
    import ram_burst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] beats_left;
    logic              inflight;
    logic [1:0]        buf_count;
    logic              buf_valid;
    logic              cmd_fire;
    logic              cmd_oob;
    logic              wr_fire;
    logic              rd_issue;
    logic              rd_pop;
    logic [2:0]        occupancy;
    logic              have_credit;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rd_valid = buf_valid && !RST;
    assign rd_pop   = rd_valid && rd_ready;
    assign busy     = (state != IDLE) && !RST;

    // words that will occupy the buffer after this edge; a new read may
    // only issue while fewer than two are buffered or in flight
    assign occupancy   = {1'b0, buf_count} + 3'(inflight) - 3'(rd_pop);
    assign have_credit = (occupancy < 3'd2);

`ifdef RAM_BURST_WRAP_EN
    assign cmd_oob = 1'b0;
    assign err     = 1'b0;
`else
    logic [ADDR_W:0] end_addr;
    logic            err_q;

    assign end_addr = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign cmd_oob  = end_addr[ADDR_W];
    assign err      = err_q && !RST;

    // one-cycle pulse for a command whose last beat would run past the top of the RAM
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= cmd_fire && cmd_oob;
        end
    end
`endif

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and RAM port drive; everything quiet while reset is held
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = cur_addr;
        ram_di    = wr_data;
        wr_fire   = 1'b0;
        rd_issue  = 1'b0;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid && !cmd_oob) begin
                        state_nxt = cmd_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        wr_fire = 1'b1;
                        ram_en  = 1'b1;
                        ram_we  = 1'b1;
                        if (beats_left == '0) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                READ: begin
                    if (have_credit) begin
                        rd_issue = 1'b1;
                        ram_en   = 1'b1;
                        if (beats_left == '0) begin
                            state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((buf_count == 2'd0) && !inflight) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // burst address/beat counters and the read-in-flight flag; address wraps naturally at ADDR_W bits
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_addr   <= '0;
            beats_left <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (cmd_fire) begin
                cur_addr   <= cmd_addr;
                beats_left <= cmd_len;
            end else if (wr_fire || rd_issue) begin
                cur_addr   <= cur_addr + ADDR_W'(1);
                beats_left <= beats_left - ADDR_W'(1);
            end
        end
    end

    ram_burst_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .CLK       (CLK),
        .RST       (RST),
        .push      (inflight),
        .push_data (ram_do),
        .out_valid (buf_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .count     (buf_count)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - scoreboard bench for ram_burst_ctrl with a read-first 64x16 RAM model
module tb_ram_burst_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [5:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        busy;
    logic        err;
    logic        ram_en;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_do;

    ram_burst_ctrl #(.ADDR_W(6), .DATA_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .err       (err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_di    (ram_di),
        .ram_do    (ram_do)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [64];
    logic [15:0] sh  [64];
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            ram_do <= mem[ram_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int issued = 0;
    int popped = 0;
    int writes = 0;
    int last_wr_cyc = 0;
    logic [15:0] rd_exp [$];
    logic [21:0] wr_exp [$];
    int          pop_cyc [$];
    logic [5:0]  iss_addr [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: samples on the falling edge, judging what the next rising edge will do
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (rd_valid && rd_ready) begin
                popped++;
                pop_cyc.push_back(cyc + 1);
                check("rd_expected_pending", 32'(rd_exp.size() != 0), 1);
                if (rd_exp.size() != 0) check("rd_data", rd_data, rd_exp.pop_front());
            end
            if (ram_en && ram_we) begin
                writes++;
                last_wr_cyc = cyc + 1;
                check("wr_only_on_handshake", 32'(wr_valid && wr_ready), 1);
                check("wr_expected_pending", 32'(wr_exp.size() != 0), 1);
                if (wr_exp.size() != 0) check("wr_addr_data", {ram_addr, ram_di}, wr_exp.pop_front());
            end
            if (ram_en && !ram_we) begin
                check("rd_occupancy_le2", 32'((issued + 1 - popped) <= 2), 1);
                issued++;
                iss_addr.push_back(ram_addr);
            end
            if (cmd_valid && cmd_ready) check("cmd_no_overlap", {busy, ram_en}, 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input int addr, input int len);
        int  n = 0;
        bit  done = 0;
        bit  oob;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = 6'(addr);
        cmd_len   = 6'(len);
        while (!done && n < 300) begin
            done = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        check("cmd_accept_in_time", 32'(done), 1);
        acc_cyc = cyc;
`ifdef RAM_BURST_WRAP_EN
        oob = 1'b0;
`else
        oob = (addr + len) > 63;
`endif
        if (!wr && !oob) begin
            for (int i = 0; i <= len; i++) rd_exp.push_back(sh[(addr + i) % 64]);
        end
    endtask

    task automatic write_data(input int addr, input int len, input int base, input bit toggle);
        bit ph = 1'b0;
        int i = 0;
        int n = 0;
        while (i <= len && n < 1000) begin
            bit fired;
            wr_valid = toggle ? ph : 1'b1;
            ph       = !ph;
            wr_data  = 16'(base + i);
            fired    = wr_valid && wr_ready;
            if (fired) begin
                wr_exp.push_back({6'((addr + i) % 64), wr_data});
                sh[(addr + i) % 64] = wr_data;
            end
            tick();
            n++;
            if (fired) i++;
        end
        wr_valid = 1'b0;
        check("wr_burst_complete", i, len + 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rd_exp.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check("idle_in_time", 32'(n < 500), 1);
    endtask

    task automatic wait_pops(input int base, input int k);
        int n = 0;
        while (popped - base < k && n < 100) begin
            tick();
            n++;
        end
        check("pops_in_time", 32'(n < 100), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int w0;
        int i0;
        logic [15:0] held;

        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'h0000;
            sh[i]  = 16'h0000;
        end
        ram_do    = 16'h0000;
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {cmd_ready, ram_en, ram_we, rd_valid, busy, err}, 0);
        RST = 1'b0;
        #1;
        check("cmd_ready_after_reset", cmd_ready, 1);

        // 1: write 10..13, read back on four consecutive cycles, first beat 3 CLK after accept
        send_cmd(1'b1, 10, 3);
        write_data(10, 3, 16'hA000, 1'b0);
        wait_idle();
        check("t1_writes_drained", wr_exp.size(), 0);
        pop_cyc.delete();
        send_cmd(1'b0, 10, 3);
        wait_idle();
        check("t1_pop_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            check("t1_first_latency", pop_cyc[0] - acc_cyc, 3);
            check("t1_consecutive", pop_cyc[3] - pop_cyc[0], 3);
        end

        // 4: 64-beat write with wr_valid toggling
        w0 = writes;
        send_cmd(1'b1, 0, 63);
        write_data(0, 63, 16'hB000, 1'b1);
        check("t4_busy_after_last", busy, 0);
        check("t4_write_count", writes - w0, 64);
        check("t4_writes_drained", wr_exp.size(), 0);

        // 2: 8-beat read with a 5-cycle stall mid-burst
        p0 = popped;
        send_cmd(1'b0, 0, 7);
        wait_pops(p0, 2);
        rd_ready = 1'b0;
        tick();
        held = rd_data;
        check("t2_valid_held", rd_valid, 1);
        for (int k = 1; k < 5; k++) begin
            check("t2_no_issue_when_full", ram_en, 0);
            tick();
            check("t2_data_held", rd_data, held);
        end
        rd_ready = 1'b1;
        wait_idle();
        check("t2_total_pops", popped - p0, 8);

        // 3: read crossing the top of the RAM
        iss_addr.delete();
        i0 = issued;
        send_cmd(1'b0, 62, 3);
`ifdef RAM_BURST_WRAP_EN
        wait_idle();
        check("t3_issue_count", iss_addr.size(), 4);
        if (iss_addr.size() == 4) begin
            check("t3_addr0", iss_addr[0], 62);
            check("t3_addr1", iss_addr[1], 63);
            check("t3_addr2", iss_addr[2], 0);
            check("t3_addr3", iss_addr[3], 1);
        end
`else
        check("t3_err_pulse", err, 1);
        check("t3_cmd_ready", cmd_ready, 1);
        check("t3_stays_idle", busy, 0);
        tick();
        check("t3_err_one_cycle", err, 0);
        repeat (3) tick();
        check("t3_no_ram_access", issued - i0, 0);
`endif

        // 5: reset after 2 of 8 read beats
        p0 = popped;
        send_cmd(1'b0, 16, 7);
        wait_pops(p0, 2);
        RST = 1'b1;
        rd_exp.delete();
        issued = 0;
        popped = 0;
        #1;
        check("t5_rst_quiet", {rd_valid, busy, ram_en}, 0);
        tick();
        RST = 1'b0;
        #1;
        check("t5_cmd_ready_after", cmd_ready, 1);
        check("t5_idle_after", {rd_valid, busy}, 0);
        send_cmd(1'b0, 10, 1);
        wait_idle();

        // 6: back-to-back write then read
        send_cmd(1'b1, 40, 2);
        fork
            write_data(40, 2, 16'hC000, 1'b1);
            send_cmd(1'b0, 40, 2);
        join
        wait_idle();
        check("t6_read_after_write", 32'(acc_cyc > last_wr_cyc), 1);

        repeat (3) tick();
        check("final_queues_empty", rd_exp.size() + wr_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
